// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM encoding and decoded-field payload for the fetch/decode front end.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JT_W    = 26;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_BR_WAIT = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [OPC_W-1:0] func;
    logic [IMM_W-1:0] raw_val;
    logic [JT_W-1:0]  jtarget;
  } dec_fields_t;

  // Sign-extended word offset of a branch immediate, as a byte displacement.
  function automatic logic [INSTR_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{14{imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_field_decoder.sv
// Combinational split of an instruction word into fields plus control-flow class flags.
module instr_field_decoder
  import cpu_pkg::*;
#(
  parameter bit EN_BNE = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_fields_t        fields,
  output logic               is_branch,
  output logic               is_jump
);

  // Fixed bit slices of the word and opcode classification.
  always_comb begin
    fields.opcode  = instr[31:26];
    fields.rs      = instr[25:21];
    fields.rt      = instr[20:16];
    fields.rd      = instr[15:11];
    fields.shamt   = instr[10:6];
    fields.func    = instr[5:0];
    fields.raw_val = instr[15:0];
    fields.jtarget = instr[25:0];
    is_branch      = (instr[31:26] == OP_BEQ) || (EN_BNE && (instr[31:26] == OP_BNE));
    is_jump        = (instr[31:26] == OP_J);
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Single-issue fetch/decode front end: fetches a word, presents its fields downstream,
// and steers the PC for sequential flow, jumps and ALU-resolved branches.
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          EN_BNE   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_VALID,
  input  logic [31:0] IMEM_DATA,
  output logic        DEC_VALID,
  input  logic        DEC_READY,
  output logic [5:0]  OPCODE,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  output logic [4:0]  RD,
  output logic [4:0]  SHAMT,
  output logic [5:0]  FUNC,
  output logic [15:0] RAW_VAL,
  output logic [31:0] PC_OUT,
  input  logic        BR_VALID,
  input  logic        SIG_B
);

  fsm_state_e         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [31:0]        target_q, target_d;
  logic               req_q, req_d;
  logic               dec_valid_q, dec_valid_d;

  dec_fields_t        fields;
  logic               is_branch;
  logic               is_jump;
  logic [31:0]        pc_plus4;

  instr_field_decoder #(
    .EN_BNE (EN_BNE)
  ) u_dec (
    .instr     (ir_q),
    .fields    (fields),
    .is_branch (is_branch),
    .is_jump   (is_jump)
  );

  assign pc_plus4 = pc_q + 32'd4;

  // State and datapath registers; reset abandons any fetch or branch in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      pc_out_q    <= '0;
      ir_q        <= '0;
      target_q    <= '0;
      req_q       <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      ir_q        <= ir_d;
      target_q    <= target_d;
      req_q       <= req_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  // Next-state, PC steering and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    ir_d        = ir_q;
    target_d    = target_q;
    req_d       = 1'b0;
    dec_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_FETCH: begin
        req_d = 1'b1;
        if (IMEM_VALID) begin
          ir_d        = IMEM_DATA;
          pc_out_d    = pc_q;
          state_d     = ST_ISSUE;
          req_d       = 1'b0;
          dec_valid_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        dec_valid_d = 1'b1;
        if (DEC_READY) begin
          dec_valid_d = 1'b0;
          if (is_branch) begin
            target_d = pc_plus4 + branch_offset(fields.raw_val);
            state_d  = ST_BR_WAIT;
          end else begin
            pc_d    = is_jump ? {pc_plus4[31:28], fields.jtarget, 2'b00} : pc_plus4;
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end
        end
      end
      ST_BR_WAIT: begin
        if (BR_VALID) begin
          pc_d    = SIG_B ? target_q : pc_plus4;
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign DEC_VALID = dec_valid_q;
  assign OPCODE    = fields.opcode;
  assign RS        = fields.rs;
  assign RT        = fields.rt;
  assign RD        = fields.rd;
  assign SHAMT     = fields.shamt;
  assign FUNC      = fields.func;
  assign RAW_VAL   = fields.raw_val;
  assign PC_OUT    = pc_out_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit against a PC-sequence reference model.
module tb_fetch_decode_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_VALID = 1'b0;
  logic [31:0] IMEM_DATA = 32'h0;
  logic        DEC_VALID;
  logic        DEC_READY = 1'b0;
  logic [5:0]  OPCODE;
  logic [4:0]  RS, RT, RD, SHAMT;
  logic [5:0]  FUNC;
  logic [15:0] RAW_VAL;
  logic [31:0] PC_OUT;
  logic        BR_VALID = 1'b0;
  logic        SIG_B = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;

  fetch_decode_unit #(.RESET_PC(32'h0000_0000), .EN_BNE(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_VALID(IMEM_VALID), .IMEM_DATA(IMEM_DATA), .DEC_VALID(DEC_VALID),
    .DEC_READY(DEC_READY), .OPCODE(OPCODE), .RS(RS), .RT(RT), .RD(RD),
    .SHAMT(SHAMT), .FUNC(FUNC), .RAW_VAL(RAW_VAL), .PC_OUT(PC_OUT),
    .BR_VALID(BR_VALID), .SIG_B(SIG_B)
  );

  always #5 CLK = ~CLK;

  // Architectural next PC from the instruction semantics.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                           input bit taken);
    int unsigned op;
    int          off;
    op = instr >> 26;
    if (op == 4 || op == 5) begin
      off = int'($signed(instr[15:0])) * 4;
      return taken ? pc + 32'd4 + 32'(off) : pc + 32'd4;
    end
    if (op == 2) return ((pc + 32'd4) & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    return pc + 32'd4;
  endfunction

  function automatic bit ref_is_branch(input logic [31:0] instr);
    return (instr >> 26) == 4 || (instr >> 26) == 5;
  endfunction

  // Wait (bounded) for a fetch request; starts and ends at a falling edge.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (IMEM_REQ === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // Answer the pending fetch after lat idle cycles; returns the requested address.
  task automatic run_fetch(input logic [31:0] word, input int lat,
                           output logic [31:0] addr, output bit ok);
    wait_req(ok);
    addr = IMEM_ADDR;
    if (!ok) return;
    repeat (lat) @(negedge CLK);
    IMEM_VALID = 1'b1;
    IMEM_DATA  = word;
    @(negedge CLK);
    IMEM_VALID = 1'b0;
    IMEM_DATA  = $urandom();
  endtask

  task automatic accept();
    DEC_READY = 1'b1;
    @(negedge CLK);
    DEC_READY = 1'b0;
  endtask

  task automatic resolve(input bit taken);
    BR_VALID = 1'b1;
    SIG_B    = taken;
    @(negedge CLK);
    BR_VALID = 1'b0;
    SIG_B    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b want=0", IMEM_REQ); end
    checks++; if (DEC_VALID !== 1'b0) begin errors++; $display("FAIL reset_dv got=%0b want=0", DEC_VALID); end
    checks++; if (PC_OUT !== 32'h0) begin errors++; $display("FAIL reset_pcout got=%h want=0", PC_OUT); end
    checks++; if ({OPCODE, RS, RT, RD, SHAMT, FUNC, RAW_VAL} !== 48'h0) begin
      errors++; $display("FAIL reset_fields got=%h want=0", {OPCODE, RS, RT, RD, SHAMT, FUNC, RAW_VAL});
    end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL first_req got=%0b want=1", IMEM_REQ); end
    checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL first_addr got=%h want=0", IMEM_ADDR); end
    exp_pc = 32'h0;
  endtask

  task automatic test_sequential();
    logic [31:0] w, word, addr;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      w = $urandom();
      word = {6'd0, w[25:6], 6'h20};
      run_fetch(word, i % 2, addr, ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_timeout got=no_req want=req"); end
      checks++; if (addr !== exp_pc) begin errors++; $display("FAIL seq_addr got=%h want=%h", addr, exp_pc); end
      checks++; if (DEC_VALID !== 1'b1) begin errors++; $display("FAIL seq_dv got=%0b want=1", DEC_VALID); end
      checks++; if (PC_OUT !== exp_pc) begin errors++; $display("FAIL seq_pcout got=%h want=%h", PC_OUT, exp_pc); end
      checks++; if ({RS, RT, RD, SHAMT, FUNC} !== word[25:0]) begin
        errors++; $display("FAIL seq_fields got=%h want=%h", {RS, RT, RD, SHAMT, FUNC}, word[25:0]);
      end
      accept();
      exp_pc = ref_next(exp_pc, word, 1'b0);
      checks++; if (IMEM_REQ !== 1'b1 || DEC_VALID !== 1'b0) begin
        errors++; $display("FAIL seq_after_accept got=req%0b/dv%0b want=req1/dv0", IMEM_REQ, DEC_VALID);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] words [3];
    bit          tk [3];
    logic [31:0] addr;
    bit ok;
    words[0] = {6'd4, 5'd1, 5'd2, 16'h0003}; tk[0] = 1'b1;
    words[1] = {6'd4, 5'd3, 5'd4, 16'h0005}; tk[1] = 1'b0;
    words[2] = {6'd4, 5'd5, 5'd6, 16'hFFFE}; tk[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_fetch(words[i], 0, addr, ok);
      checks++; if (addr !== exp_pc || !ok) begin errors++; $display("FAIL br_addr got=%h want=%h", addr, exp_pc); end
      checks++; if (RAW_VAL !== words[i][15:0]) begin errors++; $display("FAIL br_raw got=%h want=%h", RAW_VAL, words[i][15:0]); end
      accept();
      repeat (2) begin
        checks++; if (IMEM_REQ !== 1'b0 || DEC_VALID !== 1'b0) begin
          errors++; $display("FAIL br_wait got=req%0b/dv%0b want=req0/dv0", IMEM_REQ, DEC_VALID);
        end
        @(negedge CLK);
      end
      resolve(tk[i]);
      exp_pc = ref_next(exp_pc, words[i], tk[i]);
      wait_req(ok);
      checks++; if (!ok || IMEM_ADDR !== exp_pc) begin errors++; $display("FAIL br_target got=%h want=%h", IMEM_ADDR, exp_pc); end
    end
  endtask

  task automatic test_jump();
    logic [31:0] word, addr;
    bit ok;
    word = {6'd2, 26'h0000010};
    run_fetch(word, 1, addr, ok);
    checks++; if (!ok || addr !== exp_pc) begin errors++; $display("FAIL j_addr got=%h want=%h", addr, exp_pc); end
    accept();
    exp_pc = ref_next(exp_pc, word, 1'b0);
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== exp_pc) begin
      errors++; $display("FAIL j_target got=%h want=%h", IMEM_ADDR, exp_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] word, addr;
    bit ok;
    word = {6'd2, 26'h0};
    run_fetch(word, 0, addr, ok);
    accept();
    exp_pc = ref_next(exp_pc, word, 1'b0);
    word = {6'd4, 10'h0, 16'hFFFE};
    run_fetch(word, 0, addr, ok);
    checks++; if (!ok || addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h want=0", addr); end
    accept();
    resolve(1'b1);
    exp_pc = ref_next(exp_pc, word, 1'b1);
    word = {6'd0, 20'h12345, 6'h20};
    run_fetch(word, 0, addr, ok);
    checks++; if (!ok || addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%h want=fffffffc", addr); end
    accept();
    exp_pc = ref_next(exp_pc, word, 1'b0);
    checks++; if (IMEM_ADDR !== 32'h0 || exp_pc !== 32'h0) begin errors++; $display("FAIL wrap_around got=%h want=0", IMEM_ADDR); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w, word, addr, a0;
    bit ok;
    wait_req(ok);
    a0 = IMEM_ADDR;
    DEC_READY = 1'b1;
    repeat (2) @(negedge CLK);
    DEC_READY = 1'b0;
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== a0) begin
      errors++; $display("FAIL ready_idle got=req%0b/%h want=req1/%h", IMEM_REQ, IMEM_ADDR, a0);
    end
    w = $urandom();
    word = {6'd8, w[25:0]};
    run_fetch(word, 0, addr, ok);
    checks++; if (!ok || addr !== exp_pc) begin errors++; $display("FAIL bp_addr got=%h want=%h", addr, exp_pc); end
    for (int i = 0; i < 3; i++) begin
      IMEM_VALID = 1'b1;
      IMEM_DATA  = ~word;
      BR_VALID   = 1'b1;
      SIG_B      = 1'b1;
      @(negedge CLK);
      checks++; if (DEC_VALID !== 1'b1 || IMEM_REQ !== 1'b0) begin
        errors++; $display("FAIL bp_hold got=dv%0b/req%0b want=dv1/req0", DEC_VALID, IMEM_REQ);
      end
      checks++; if (PC_OUT !== exp_pc || {OPCODE, RS, RT, RD, SHAMT, FUNC} !== word) begin
        errors++; $display("FAIL bp_stable got=%h/%h want=%h/%h", PC_OUT, {OPCODE, RS, RT, RD, SHAMT, FUNC}, exp_pc, word);
      end
    end
    IMEM_VALID = 1'b0;
    BR_VALID   = 1'b0;
    SIG_B      = 1'b0;
    accept();
    exp_pc = ref_next(exp_pc, word, 1'b0);
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== exp_pc) begin
      errors++; $display("FAIL bp_next got=%h want=%h", IMEM_ADDR, exp_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] w, word, addr;
    bit ok, taken;
    int kind;
    for (int n = 0; n < 40; n++) begin
      w = $urandom();
      kind = $urandom_range(0, 4);
      case (kind)
        0: word = {6'd0, w[25:0]};
        1: word = {6'd4, w[25:0]};
        2: word = {6'd5, w[25:0]};
        3: word = {6'd2, w[25:0]};
        default: word = {6'($urandom_range(6, 63)), w[25:0]};
      endcase
      taken = 1'($urandom_range(0, 1));
      run_fetch(word, $urandom_range(0, 2), addr, ok);
      checks++; if (!ok || addr !== exp_pc) begin errors++; $display("FAIL rnd_addr n=%0d got=%h want=%h", n, addr, exp_pc); end
      checks++; if (DEC_VALID !== 1'b1 || PC_OUT !== exp_pc) begin
        errors++; $display("FAIL rnd_issue n=%0d got=dv%0b/%h want=dv1/%h", n, DEC_VALID, PC_OUT, exp_pc);
      end
      checks++; if (OPCODE !== word[31:26] || RAW_VAL !== word[15:0] || RS !== word[25:21]) begin
        errors++; $display("FAIL rnd_fields n=%0d got=%h/%h/%h want=%h/%h/%h", n, OPCODE, RAW_VAL, RS,
                           word[31:26], word[15:0], word[25:21]);
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      accept();
      if (ref_is_branch(word)) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rnd_brwait n=%0d got=%0b want=0", n, IMEM_REQ); end
        resolve(taken);
      end
      exp_pc = ref_next(exp_pc, word, taken);
    end
    wait_req(ok);
    checks++; if (!ok || IMEM_ADDR !== exp_pc) begin errors++; $display("FAIL rnd_final got=%h want=%h", IMEM_ADDR, exp_pc); end
  endtask

  task automatic test_reset_in_br_wait();
    logic [31:0] word, addr;
    bit ok;
    word = {6'd5, 5'd1, 5'd2, 16'h0100};
    run_fetch(word, 0, addr, ok);
    accept();
    BR_VALID   = 1'b1;
    SIG_B      = 1'b1;
    IMEM_VALID = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    checks++; if (IMEM_REQ !== 1'b0 || DEC_VALID !== 1'b0) begin
      errors++; $display("FAIL rst_async got=req%0b/dv%0b want=0/0", IMEM_REQ, DEC_VALID);
    end
    checks++; if (PC_OUT !== 32'h0 || {OPCODE, RAW_VAL} !== 22'h0) begin
      errors++; $display("FAIL rst_clear got=%h/%h want=0/0", PC_OUT, {OPCODE, RAW_VAL});
    end
    repeat (2) @(negedge CLK);
    BR_VALID   = 1'b0;
    SIG_B      = 1'b0;
    IMEM_VALID = 1'b0;
    RST_N      = 1'b1;
    @(negedge CLK);
    exp_pc = 32'h0;
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0 || DEC_VALID !== 1'b0) begin
      errors++; $display("FAIL rst_refetch got=req%0b/%h want=req1/0", IMEM_REQ, IMEM_ADDR);
    end
    word = {6'd0, 26'h0AB_CDEF};
    run_fetch(word, 0, addr, ok);
    checks++; if (!ok || PC_OUT !== 32'h0 || FUNC !== word[5:0]) begin
      errors++; $display("FAIL rst_issue got=%h/%h want=0/%h", PC_OUT, FUNC, word[5:0]);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_in_br_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
